// File: rtl/eth_fcs_tx_ctrl.sv
// eth_fcs_tx_ctrl
//   Transmit-side frame controller for an external CRC-32 engine. It passes
//   payload bytes through, optionally zero-pads short frames up to MIN_LEN
//   bytes, appends the 4-byte FCS taken from the engine register, and then
//   enforces an inter-frame gap.
//
// Parameters
//   PAD_EN     : 1 = zero-pad short frames up to MIN_LEN bytes before the FCS
//   MIN_LEN    : minimum payload + pad byte count (1..2047)
//   IFG_CYCLES : idle cycles forced after the last FCS byte (1..255)
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready     : payload input handshake
//   out_valid/out_data/out_last/out_ready : frame output handshake
//   crc_en, crc_clr, crc_din : CRC engine update enable, clear, data byte
//   crc_data             : CRC engine register value
//   busy                 : high whenever the controller is not idle
module eth_fcs_tx_ctrl #(
  parameter bit          PAD_EN     = 1'b1,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_en,
  output logic        crc_clr,
  output logic [7:0]  crc_din,
  input  logic [31:0] crc_data,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, GAP} state_t;

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [11:0] MIN_LEN_W = {1'b0, MIN_LEN_C};
  localparam logic [7:0]  GAP_LAST  = 8'(IFG_CYCLES - 1);

  state_t      state, state_next;
  logic [10:0] byte_cnt;
  logic [11:0] cnt_plus1;
  logic [1:0]  fcs_idx;
  logic [7:0]  gap_cnt;

  logic        in_ready_i, out_valid_i, out_last_i, crc_en_i, crc_clr_i;
  logic [7:0]  out_data_i;
  logic [7:0]  crc_sel, fcs_byte;
  logic        in_xfer, out_xfer, short_frame;

  // Byte count including the byte being transferred this cycle.
  assign cnt_plus1   = {1'b0, byte_cnt} + 12'd1;
  assign short_frame = PAD_EN && (cnt_plus1 < MIN_LEN_W);
  assign in_xfer     = in_valid & in_ready_i;
  assign out_xfer    = out_valid_i & out_ready;

  // FCS byte k is the complemented, bit-reversed crc_data[31-8k:24-8k]. The
  // engine register already holds the final value when FCS is entered, since
  // its last update and the state change share the same edge.
  always_comb begin
    crc_sel  = '0;
    fcs_byte = '0;
    case (fcs_idx)
      2'd0: crc_sel = crc_data[31:24];
      2'd1: crc_sel = crc_data[23:16];
      2'd2: crc_sel = crc_data[15:8];
      default: crc_sel = crc_data[7:0];
    endcase
    for (int unsigned i = 0; i < 8; i++) begin
      fcs_byte[i] = ~crc_sel[7-i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          if (in_last) begin
            state_next = short_frame ? PAD : FCS;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (in_xfer && in_last) begin
          state_next = short_frame ? PAD : FCS;
        end
      end
      PAD: begin
        if (out_xfer && (cnt_plus1 >= MIN_LEN_W)) begin
          state_next = FCS;
        end
      end
      FCS: begin
        if (out_xfer && (fcs_idx == 2'd3)) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic (pre-reset-gating)
  always_comb begin
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    out_data_i  = '0;
    out_last_i  = 1'b0;
    crc_en_i    = 1'b0;
    crc_clr_i   = 1'b0;
    case (state)
      IDLE, DATA: begin
        in_ready_i  = out_ready;
        out_valid_i = in_valid;
        out_data_i  = in_data;
        crc_en_i    = in_valid & out_ready;
      end
      PAD: begin
        out_valid_i = 1'b1;
        out_data_i  = '0;
        crc_en_i    = out_ready;
      end
      FCS: begin
        out_valid_i = 1'b1;
        out_data_i  = fcs_byte;
        out_last_i  = (fcs_idx == 2'd3);
        crc_clr_i   = (fcs_idx == 2'd3) & out_ready;
      end
      default: begin
      end
    endcase
  end

  // The IDLE pass-through would otherwise echo in_valid/in_data while reset
  // is held, so every output is forced low directly by rst_n.
  assign in_ready  = rst_n & in_ready_i;
  assign out_valid = rst_n & out_valid_i;
  assign out_data  = rst_n ? out_data_i : 8'h00;
  assign out_last  = rst_n & out_last_i;
  assign crc_en    = rst_n & crc_en_i;
  assign crc_clr   = rst_n & crc_clr_i;
  assign crc_din   = out_data;
  assign busy      = rst_n & (state != IDLE);

  // Byte, FCS index and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      fcs_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == GAP && state_next == IDLE) begin
        byte_cnt <= '0;
      end else if (crc_en_i && (byte_cnt != MIN_LEN_C)) begin
        byte_cnt <= byte_cnt + 11'd1;
      end

      if (state == FCS && out_xfer) begin
        fcs_idx <= fcs_idx + 2'd1;
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Testbench for eth_fcs_tx_ctrl. Two instances (PAD_EN=1 and PAD_EN=0) share
// the stimulus; only the selected one receives in_valid. Expected frames are
// built from the payload with a reflected CRC-32 reference and pushed into a
// scoreboard queue; a monitor pops and compares on each output transfer.
module tb_eth_fcs_tx_ctrl;

  localparam int unsigned MIN_LEN = 60;
  localparam int unsigned IFG     = 12;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         fcs;
    int         en;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic        ir_p, ov_p, ol_p, ce_p, cc_p, bz_p;
  logic [7:0]  od_p, cd_p;
  logic [31:0] crc_p;
  logic        ir_n, ov_n, ol_n, ce_n, cc_n, bz_n;
  logic [7:0]  od_n, cd_n;
  logic [31:0] crc_n;

  eth_fcs_tx_ctrl #(.PAD_EN(1'b1), .MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG)) u_pad (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_p), .out_valid(ov_p), .out_data(od_p),
    .out_last(ol_p), .out_ready(out_ready), .crc_en(ce_p), .crc_clr(cc_p),
    .crc_din(cd_p), .crc_data(crc_p), .busy(bz_p));

  eth_fcs_tx_ctrl #(.PAD_EN(1'b0), .MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG)) u_nopad (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_n), .out_valid(ov_n), .out_data(od_n),
    .out_last(ol_n), .out_ready(out_ready), .crc_en(ce_n), .crc_clr(cc_n),
    .crc_din(cd_n), .crc_data(crc_n), .busy(bz_n));

  // External CRC engine model: MSB-first register fed each byte LSB first.
  function automatic logic [31:0] eng_step(input logic [31:0] r, input logic [7:0] d);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_p <= '1;
      crc_n <= '1;
    end else begin
      if (cc_p) crc_p <= '1;
      else if (ce_p) crc_p <= eng_step(crc_p, cd_p);
      if (cc_n) crc_n <= '1;
      else if (ce_n) crc_n <= eng_step(crc_n, cd_n);
    end
  end

  logic       m_ir, m_ov, m_ol, m_ce, m_cc, m_bz;
  logic [7:0] m_od, m_cd;
  assign m_ir = sel ? ir_n : ir_p;
  assign m_ov = sel ? ov_n : ov_p;
  assign m_ol = sel ? ol_n : ol_p;
  assign m_ce = sel ? ce_n : ce_p;
  assign m_cc = sel ? cc_n : cc_p;
  assign m_bz = sel ? bz_n : bz_p;
  assign m_od = sel ? od_n : od_p;
  assign m_cd = sel ? cd_n : cd_p;

  int    errors = 0, checks = 0;
  item_t exp_q[$];
  logic [7:0] pl[$];
  int    xfer_cnt = 0, stop_at = 0, or_mode = 0;
  int    en_cnt = 0, clr_total = 0, frames_done = 0, frames_exp = 0;
  bit    stall_prev = 0, gap_on = 0;
  logic [7:0] stall_data = 8'h00;
  int    gap_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: standard reflected CRC-32 over the byte sequence.
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_expected(input bit pad_en);
    logic [7:0]  fr[$];
    logic [31:0] crc;
    item_t       it;
    fr = pl;
    if (pad_en) while (fr.size() < MIN_LEN) fr.push_back(8'h00);
    crc = ref_crc(fr);
    foreach (fr[i]) begin
      it = '{d: fr[i], last: 1'b0, fcs: 1'b0, en: 0};
      exp_q.push_back(it);
    end
    for (int k = 0; k < 4; k++) begin
      it = '{d: crc[8*k +: 8], last: (k == 3), fcs: 1'b1, en: fr.size()};
      exp_q.push_back(it);
    end
  endtask

  // Sends pl; gap >= 0 inserts that many idle cycles after each byte,
  // gap < 0 inserts a random 0..2.
  task automatic send_frame(input int gap);
    bit acc;
    int n, g;
    push_expected(!sel);
    frames_exp++;
    foreach (pl[i]) begin
      in_valid = 1'b1;
      in_data  = pl[i];
      in_last  = (i == pl.size() - 1);
      acc = 0;
      n = 0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = m_ir;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic load_ascii();
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  task automatic load_random(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // out_ready driver
  always begin
    @(posedge clk); #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = (xfer_cnt < stop_at);
    endcase
  end

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    item_t e;
    if (!rst_n) begin
      stall_prev = 0;
      en_cnt     = 0;
      gap_on     = 0;
      gap_cnt    = 0;
    end else begin
      if (m_cc) clr_total++;
      if (m_ce) en_cnt++;
      if (stall_prev) chk("hold_stable", {23'h0, m_ov, m_od}, {23'h0, 1'b1, stall_data});
      if (gap_on) begin
        if (m_bz) begin
          if (!m_ir && !m_ov) gap_cnt++;
          else gap_cnt += 100;
        end else begin
          chk("ifg_len", gap_cnt, IFG);
          gap_on = 0;
        end
      end
      if (m_ov && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h expected=none t=%0t", m_od, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_od, e.d);
          chk("crc_din", m_cd, e.d);
          chk("out_last", m_ol, e.last);
          chk("crc_en", m_ce, !e.fcs);
          if (e.last) begin
            chk("crc_clr", m_cc, 1);
            chk("crc_en_count", en_cnt, e.en);
            en_cnt = 0;
            frames_done++;
            gap_on  = 1;
            gap_cnt = 0;
          end
        end
      end
      stall_prev = m_ov && !out_ready;
      stall_data = m_od;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with active-looking inputs
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #12;
    chk("rst_out_valid", {ov_p, ov_n}, 2'b00);
    chk("rst_out_data", {od_p, od_n}, 16'h0000);
    chk("rst_out_last", {ol_p, ol_n}, 2'b00);
    chk("rst_crc_en", {ce_p, ce_n}, 2'b00);
    chk("rst_crc_clr", {cc_p, cc_n}, 2'b00);
    chk("rst_busy", {bz_p, bz_n}, 2'b00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // PAD_EN=0 instance
    sel = 1'b1;
    load_ascii();
    send_frame(0);
    wait_drain();

    load_random(10);
    send_frame(3);
    wait_drain();

    // Reset while FCS byte 2 is pending
    load_ascii();
    stop_at = xfer_cnt + 11;
    or_mode = 3;
    push_expected(1'b0);
    foreach (pl[i]) begin
      in_valid = 1'b1; in_data = pl[i]; in_last = (i == 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    begin
      int n = 0;
      while (xfer_cnt < stop_at && n < 1000) begin @(negedge clk); n++; end
      if (xfer_cnt < stop_at) chk("fcs_stall_timeout", xfer_cnt, stop_at);
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov_n, 1'b0);
    chk("midrst_busy", bz_n, 1'b0);
    chk("midrst_out_last", ol_n, 1'b0);
    exp_q.delete();
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_ascii();
    send_frame(0);
    wait_drain();

    or_mode = 2;
    for (int f = 0; f < 5; f++) begin
      load_random(int'($urandom_range(1, 70)));
      send_frame(-1);
    end
    or_mode = 0;
    wait_drain();

    // PAD_EN=1 instance
    sel = 1'b0;
    pl = {8'hAA};
    send_frame(0);
    wait_drain();

    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    or_mode = 1;
    send_frame(0);
    wait_drain();
    or_mode = 0;

    load_random(60);
    send_frame(0);
    load_random(60);
    send_frame(0);
    wait_drain();

    or_mode = 2;
    foreach (pl[i]) pl[i] = pl[i];
    for (int f = 0; f < 6; f++) begin
      case (f)
        0: load_random(1);
        1: load_random(59);
        2: load_random(61);
        default: load_random(int'($urandom_range(2, 80)));
      endcase
      send_frame(-1);
    end
    or_mode = 0;
    wait_drain();

    chk("frames_done", frames_done, frames_exp);
    chk("crc_clr_pulses", clr_total, frames_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_fcs_tx_ctrl.md
ETH_FCS_TX_CTRL -- requirements
Module: eth_fcs_tx_ctrl

Interface
REQ-001 Parameter PAD_EN, default 1, meaning: 1 = zero-pad short frames up to MIN_LEN bytes before the FCS.
REQ-002 Parameter MIN_LEN, default 60, meaning: minimum count of payload plus pad bytes (range 1..2047).
REQ-003 Parameter IFG_CYCLES, default 12, meaning: idle cycles forced after the last FCS byte (range 1..255).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  payload byte available.
REQ-007 in_data  input  8  payload byte.
REQ-008 in_last  input  1  qualifies in_data as the final payload byte of the frame.
REQ-009 in_ready  output  1  controller accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_data  output  8  frame byte (payload, pad or FCS).
REQ-012 out_last  output  1  qualifies out_data as the final FCS byte.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 crc_en  output  1  CRC engine update enable for this cycle.
REQ-015 crc_clr  output  1  CRC engine synchronous clear to 0xFFFFFFFF.
REQ-016 crc_din  output  8  byte presented to the CRC engine; always equal to out_data.
REQ-017 crc_data  input  32  CRC engine register, which updates on the clock edge ending a crc_en cycle.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 States SHALL be IDLE, DATA, PAD, FCS and GAP, held in a registered state register.
REQ-020 A transfer on either port SHALL occur only on a cycle where valid and ready are both high.
REQ-021 In IDLE and DATA, in_ready SHALL equal out_ready, out_valid SHALL equal in_valid, and out_data SHALL equal in_data (combinational pass-through).
REQ-022 In PAD, FCS and GAP, in_ready SHALL be 0.
REQ-023 crc_en SHALL be 1 exactly on output transfers of payload or pad bytes, and 0 during FCS and GAP.
REQ-024 An 11-bit byte counter SHALL count payload and pad transfers, saturate at MIN_LEN, and clear on entry to IDLE.
REQ-025 An input transfer in IDLE without in_last SHALL move the state to DATA.
REQ-026 An input transfer with in_last (in IDLE or DATA) SHALL move the state to PAD if PAD_EN=1 and the count including this byte is below MIN_LEN; otherwise to FCS.
REQ-027 PAD SHALL drive out_valid=1 and out_data=0x00, and leave for FCS on the transfer that brings the count to MIN_LEN.
REQ-028 FCS SHALL drive out_valid=1 and emit 4 bytes in order k=0..3; byte k SHALL be the bitwise complement of the bit-reversed crc_data[31-8k : 24-8k].
REQ-029 Because the state registers on the same edge as the final CRC update, the FCS bytes SHALL use crc_data directly, with no extra latency.
REQ-030 A 2-bit FCS index SHALL advance only on transfer; out_last SHALL be 1 only with FCS byte 3.
REQ-031 crc_clr SHALL pulse for exactly one cycle, on the cycle FCS byte 3 transfers; the state SHALL then enter GAP.
REQ-032 GAP SHALL hold out_valid=0 for IFG_CYCLES cycles, then return to IDLE.
REQ-033 When out_ready=0, out_data, out_valid and the FCS index SHALL hold, and crc_en SHALL be 0.
REQ-034 in_valid=0 in DATA SHALL insert idle cycles without ending the frame.
REQ-035 A 1-byte frame arriving in IDLE with in_last SHALL go directly to PAD or FCS.

Reset
REQ-036 rst_n low SHALL immediately force: state IDLE, counters 0, out_valid 0, out_last 0, crc_en 0, crc_clr 0, busy 0, out_data 0x00.
REQ-037 in_ready SHALL follow out_ready once in IDLE.
REQ-038 Reset mid-frame SHALL discard the frame; the CRC engine shares rst_n and returns to 0xFFFFFFFF, so no crc_clr pulse is required.

Verification
REQ-039 PAD_EN=0, input "123456789" (9 ASCII bytes), out_ready=1 -> 13 output bytes; last 4 = 0x26 0x39 0xF4 0xCB; out_last on byte 13; one crc_clr pulse.
REQ-040 PAD_EN=1, 1-byte frame 0xAA -> 0xAA, then 59 bytes of 0x00, then 4 FCS bytes (64 total); crc_en high for exactly 60 cycles; FCS matches a software CRC-32.
REQ-041 60-byte frame 0x00..0x3B with out_ready toggling 1,0,1,0 -> 64 bytes, none lost or duplicated; data held stable while out_ready=0; crc_en count = 60.
REQ-042 Two back-to-back 64-byte frames -> in_ready=0 for 12 cycles after the first out_last; the second frame's FCS equals its software CRC (engine cleared).
REQ-043 rst_n low while FCS byte 2 is pending -> out_valid=0 and busy=0 asynchronously; after release, the next frame "123456789" with PAD_EN=0 still ends 0x26 0x39 0xF4 0xCB.
REQ-044 PAD_EN=0, 10-byte frame with in_valid gaps of 3 cycles -> 14 output bytes; no pad bytes; crc_en count = 10.
